// File: rtl/vec_mem_responder.sv
// vec_mem_responder: memory-side engine for 256-bit vector load/store requests.
// A request is split into 16 lane accesses at base + i*stride (word addresses, mod 2^15).
// Each lane is steered to bank A[3:0], row A[14:4]. Lanes that collide on one bank are
// serialized lowest-lane-first. Load data is gathered one cycle after each grant and
// returned as a single 256-bit response through a valid/ready handshake.
module vec_mem_responder #(
   parameter int LANES  = 16,
   parameter int WORD_W = 16,
   parameter int ROW_W  = 11
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_store,
   input  logic [15:0]             req_base,
   input  logic [15:0]             req_stride,
   input  logic [LANES*WORD_W-1:0] req_wdata,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [LANES*WORD_W-1:0] resp_data,
   output logic [LANES*ROW_W-1:0]  bank_raddr,
   input  logic [LANES*WORD_W-1:0] bank_rdata,
   output logic [LANES-1:0]        bank_wen,
   output logic [LANES*ROW_W-1:0]  bank_waddr,
   output logic [LANES*WORD_W-1:0] bank_wdata
);

   localparam int ADDR_W = 15;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_next_state;
   logic [ADDR_W-1:0]         r_base;
   logic [ADDR_W-1:0]         r_stride;
   logic                      r_store;
   logic [LANES*WORD_W-1:0]   r_wdata;
   logic [LANES-1:0]          r_pending;
   logic [LANES-1:0]          r_prev_grant;
   logic [LANES*WORD_W-1:0]   r_result;

   logic [ADDR_W-1:0]         w_addr [LANES];
   logic [ADDR_W-1:0]         w_acc;
   logic [LANES-1:0]          w_grant;
   logic [LANES-1:0]          w_bank_busy;
   logic                      w_accept;
   logic                      w_unused_bits;

   // Byte-address bit 0 and stride bit 15 carry no meaning for word addressing.
   assign w_unused_bits = req_base[0] ^ req_stride[15];

   assign resp_data = r_result;

   // Per-lane word addresses, built by repeated addition of the latched stride.
   always_comb begin
      w_acc = r_base;
      for (int i = 0; i < LANES; i++) begin
         w_addr[i] = w_acc;
         w_acc     = w_acc + r_stride;
      end
   end

   // Bank arbitration: each bank grants the lowest-numbered pending lane that maps to it.
   always_comb begin
      w_grant     = 16'h0000;
      w_bank_busy = 16'h0000;
      if (r_state == S_ISSUE) begin
         for (int i = 0; i < LANES; i++) begin
            if (r_pending[i] && !w_bank_busy[w_addr[i][3:0]]) begin
               w_grant[i]                  = 1'b1;
               w_bank_busy[w_addr[i][3:0]] = 1'b1;
            end else begin
               w_grant[i] = 1'b0;
            end
         end
      end else begin
         w_grant = 16'h0000;
      end
   end

   // Steer granted lanes onto their banks; writes are suppressed while rst is high.
   always_comb begin
      bank_raddr = '0;
      bank_waddr = '0;
      bank_wdata = '0;
      bank_wen   = 16'h0000;
      for (int i = 0; i < LANES; i++) begin
         if (w_grant[i]) begin
            bank_raddr[int'(w_addr[i][3:0])*ROW_W +: ROW_W]   = w_addr[i][14:4];
            bank_waddr[int'(w_addr[i][3:0])*ROW_W +: ROW_W]   = w_addr[i][14:4];
            bank_wdata[int'(w_addr[i][3:0])*WORD_W +: WORD_W] = r_wdata[i*WORD_W +: WORD_W];
            bank_wen[w_addr[i][3:0]]                          = r_store & ~rst;
         end else begin
            bank_wen[w_addr[i][3:0]] = bank_wen[w_addr[i][3:0]];
         end
      end
   end

   // FSM next state and handshake outputs.
   always_comb begin
      w_next_state = r_state;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_accept     = 1'b1;
               w_next_state = S_ISSUE;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_ISSUE: begin
            if ((r_pending & ~w_grant) == 16'h0000) begin
               // Stores have nothing to gather; loads need one more cycle for the last read.
               w_next_state = r_store ? S_RESP : S_DRAIN;
            end else begin
               w_next_state = S_ISSUE;
            end
         end
         S_DRAIN: begin
            w_next_state = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_RESP;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Latch the request at acceptance and retire granted lanes from the pending mask.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_base    <= 15'd0;
         r_stride  <= 15'd0;
         r_store   <= 1'b0;
         r_wdata   <= '0;
         r_pending <= 16'h0000;
      end else if (w_accept) begin
         r_base    <= req_base[15:1];
         r_stride  <= req_stride[14:0];
         r_store   <= req_store;
         r_wdata   <= req_wdata;
         r_pending <= 16'hFFFF;
      end else if (r_state == S_ISSUE) begin
         r_pending <= r_pending & ~w_grant;
      end else begin
         r_pending <= r_pending;
      end
   end

   // Gather load data: lanes granted last cycle pick up their bank's read data now.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev_grant <= 16'h0000;
         r_result     <= '0;
      end else begin
         r_prev_grant <= w_grant;
         if (w_accept) begin
            r_result <= '0;
         end else begin
            for (int i = 0; i < LANES; i++) begin
               if (r_prev_grant[i] && !r_store) begin
                  r_result[i*WORD_W +: WORD_W] <= bank_rdata[int'(w_addr[i][3:0])*WORD_W +: WORD_W];
               end
            end
         end
      end
   end

endmodule

// File: doc/vec_mem_responder.md
Name: vec_mem_responder

Overview:
- Memory-side responder for CPU vector load/store (vld/vst) requests against the 16 interleaved 16-bit data banks.
- Splits one 256-bit vector access into 16 lane accesses at base + i*stride and issues them to banks, serializing bank conflicts.
- Reassembles load lanes and returns one 256-bit response through a valid/ready handshake.
- Sits between the CPU memory stage and the mem_bank0..15 instances; banks have 1-cycle read latency.

Parameters:
- LANES, 16, vector lanes; also the bank count (fixed, one bank per lane).
- WORD_W, 16, lane/bank data width.
- ROW_W, 11, bank row address width (15-bit word address minus 4 bank-select bits).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_store  in  1  1 = vector store, 0 = vector load
- req_base  in  16  byte address; bit 0 ignored, word address = req_base[15:1]
- req_stride  in  16  lane stride in words, two's complement; only the low 15 bits are used
- req_wdata  in  256  store data; lane i = bits [16i+15:16i]
- resp_valid  out  1  response present
- resp_ready  in  1  CPU accepts response
- resp_data  out  256  load result, lane i = bits [16i+15:16i]; zero for stores
- bank_raddr  out  176  bank k row = bits [11k+10:11k]
- bank_rdata  in  256  bank k data = bits [16k+15:16k], valid the cycle after its raddr
- bank_wen  out  16  per-bank write enable
- bank_waddr  out  176  same packing as bank_raddr
- bank_wdata  out  256  same packing as bank_rdata

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst.
- Reset: state IDLE, pending mask 0, req_ready=1, resp_valid=0, resp_data=0, bank_wen=0.
- bank_wen is forced to 0 combinationally while rst=1.
- rst asserted mid-operation abandons the vector: no further bank writes, and no response is issued.
- Lane word address: A_i = (req_base[15:1] + i*req_stride[14:0]) mod 2^15.
  - bank = A_i[3:0]; row = A_i[14:4].
  - Base, stride, store flag and wdata are latched at acceptance.
- State IDLE:
  - req_ready=1.
  - On req_valid && req_ready: latch the request, set pending=16'hFFFF, go to ISSUE.
- State ISSUE, every cycle:
  - For each bank k, grant the lowest-numbered pending lane mapped to k.
  - Loads drive bank_raddr[k] with that lane's row.
  - Stores drive bank_wen[k]=1, bank_waddr[k] and bank_wdata[k] with that lane's row and data.
  - Granted lanes are cleared from pending at the clock edge.
  - Ungranted banks: wen=0, address don't-care.
- Load capture:
  - Each cycle, for every lane granted in the previous cycle, write bank_rdata of its bank into that lane's result slot.
  - This overlaps with ongoing issue.
- Transitions out of ISSUE:
  - When pending becomes 0, loads go to DRAIN (captures the last grant's data) and then RESP.
  - Stores go directly to RESP.
- State RESP:
  - resp_valid=1; resp_data stable until the handshake.
  - On resp_ready, go to IDLE.
  - req_ready=0 in every state except IDLE, so no new request is accepted in the handshake cycle.
- Latency, counting from the acceptance edge:
  - A load needing G issue cycles raises resp_valid after G+2 cycles.
  - A store raises it after G+1 cycles.
  - G = max lanes mapped to one bank: stride 1 gives G=1; stride 2 gives 2; stride 0 or 16 gives 16.
- Same-address store lanes (stride 0, or wrapped aliasing): written in ascending lane order, one per cycle, so the highest lane wins.
- Address wrap past 0x7FFF words wraps to 0 with no error.
- Negative stride is allowed via mod-2^15 arithmetic.

Test Plan:
- Load, base=0x0000, stride=1, banks preloaded mem[w]=w -> all 16 bank reads in one cycle; resp_valid 3 cycles after accept; lane i = i.
- Load, base=0x0020 (word 0x10), stride=2 -> 2 issue cycles, resp_valid at +4; lane i = 0x10+2i.
- Store, base=0x0000, stride=0, wdata lane i = 0xA000+i -> 16 single-bank writes to row 0 of bank 0, lanes 0..15 in order; final mem[0]=0xA00F; resp_valid at +17, resp_data=0.
- Load, base=0xFFFE (word 0x7FFF), stride=1 -> lane 0 reads 0x7FFF, lanes 1..15 read words 0x0000..0x000E.
- Stride 1 load completed with resp_ready held 0 for 5 cycles -> resp_valid and resp_data stable; req_ready=0 throughout; returns to IDLE the cycle after resp_ready=1.
- Stride 0 store, rst pulsed during the 3rd issue cycle -> only lanes 0..1 written; next cycle IDLE, req_ready=1, resp_valid=0.
